// File: rtl/serpent_xts_sector_ctrl.sv
// XTS-style sector sequencer for one shared Serpent encrypt core.
// It encrypts the tweak with key2, then runs C = E_k1(P ^ T) ^ T per block and advances T by alpha.
module serpent_xts_sector_ctrl #(
  parameter int CNT_W = 16,
  parameter int TMO_W = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [255:0]     i_key1,
  input  logic [255:0]     i_key2,
  input  logic [127:0]     i_sector,
  input  logic [CNT_W-1:0] i_num_blocks,
  output logic             o_busy,
  input  logic [127:0]     i_data,
  input  logic             i_data_valid,
  output logic             o_data_ready,
  output logic [127:0]     o_data,
  output logic             o_data_valid,
  input  logic             i_data_ready,
  output logic             o_done,
  output logic             o_error,
  output logic [255:0]     o_core_key,
  output logic             o_core_key_load,
  input  logic             i_core_key_ready,
  output logic [127:0]     o_core_data,
  output logic             o_core_start,
  input  logic [127:0]     i_core_data,
  input  logic             i_core_valid
);

  typedef enum logic [3:0] {
    S_IDLE, S_K2LD, S_K2W, S_TWR, S_TWW, S_K1LD,
    S_K1W,  S_IN,   S_BREQ, S_BW, S_OUT, S_DONE
  } state_e;

  // Last watchdog value still allowed: the wait state has then lasted 2^TMO_W-1 cycles.
  localparam logic [TMO_W-1:0] WDOG_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_e             state_q,     state_d;
  logic [255:0]       key1_q,      key1_d;
  logic [127:0]       sector_q,    sector_d;
  logic [CNT_W-1:0]   num_q,       num_d;
  logic [CNT_W-1:0]   count_q,     count_d;
  logic [127:0]       tweak_q,     tweak_d;
  logic [TMO_W-1:0]   wdog_q,      wdog_d;
  logic [255:0]       core_key_q,  core_key_d;
  logic [127:0]       core_data_q, core_data_d;
  logic [127:0]       data_out_q,  data_out_d;
  logic               error_q,     error_d;
  logic               waiting;
  logic               responded;

  function automatic logic [127:0] mul_alpha(input logic [127:0] t);
    return {t[126:0], 1'b0} ^ (t[127] ? 128'h87 : 128'h0);
  endfunction

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves a latch behind.
    state_d     = state_q;
    key1_d      = key1_q;
    sector_d    = sector_q;
    num_d       = num_q;
    count_d     = count_q;
    tweak_d     = tweak_q;
    wdog_d      = wdog_q;
    core_key_d  = core_key_q;
    core_data_d = core_data_q;
    data_out_d  = data_out_q;
    error_d     = 1'b0;
    waiting     = 1'b0;
    responded   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          key1_d     = i_key1;
          sector_d   = i_sector;
          num_d      = i_num_blocks;
          count_d    = '0;
          core_key_d = i_key2;
          state_d    = (i_num_blocks == '0) ? S_DONE : S_K2LD;
        end
      end
      S_K2LD: begin
        wdog_d  = '0;
        state_d = S_K2W;
      end
      S_K2W: begin
        waiting   = 1'b1;
        responded = i_core_key_ready;
        if (i_core_key_ready) begin
          core_data_d = sector_q;
          state_d     = S_TWR;
        end
      end
      S_TWR: begin
        wdog_d  = '0;
        state_d = S_TWW;
      end
      S_TWW: begin
        waiting   = 1'b1;
        responded = i_core_valid;
        if (i_core_valid) begin
          tweak_d    = i_core_data;
          core_key_d = key1_q;
          state_d    = S_K1LD;
        end
      end
      S_K1LD: begin
        wdog_d  = '0;
        state_d = S_K1W;
      end
      S_K1W: begin
        waiting   = 1'b1;
        responded = i_core_key_ready;
        if (i_core_key_ready) state_d = S_IN;
      end
      S_IN: begin
        if (i_data_valid) begin
          core_data_d = i_data ^ tweak_q;
          state_d     = S_BREQ;
        end
      end
      S_BREQ: begin
        wdog_d  = '0;
        state_d = S_BW;
      end
      S_BW: begin
        waiting   = 1'b1;
        responded = i_core_valid;
        if (i_core_valid) begin
          data_out_d = i_core_data ^ tweak_q;
          tweak_d    = mul_alpha(tweak_q);
          count_d    = count_q + 1'b1;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (i_data_ready) state_d = (count_q == num_q) ? S_DONE : S_IN;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A core that never answers abandons the sector; late answers land in IDLE and are dropped.
    if (waiting && !responded) begin
      if (wdog_q == WDOG_LAST) begin
        state_d = S_IDLE;
        error_d = 1'b1;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      key1_q      <= '0;
      sector_q    <= '0;
      num_q       <= '0;
      count_q     <= '0;
      tweak_q     <= '0;
      wdog_q      <= '0;
      core_key_q  <= '0;
      core_data_q <= '0;
      data_out_q  <= '0;
      error_q     <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state_q     <= state_d;
      key1_q      <= key1_d;
      sector_q    <= sector_d;
      num_q       <= num_d;
      count_q     <= count_d;
      tweak_q     <= tweak_d;
      wdog_q      <= wdog_d;
      core_key_q  <= core_key_d;
      core_data_q <= core_data_d;
      data_out_q  <= data_out_d;
      error_q     <= error_d;
    end
  end

  assign o_busy          = (state_q != S_IDLE);
  assign o_data_ready    = (state_q == S_IN);
  assign o_data_valid    = (state_q == S_OUT);
  assign o_done          = (state_q == S_DONE);
  assign o_core_key_load = (state_q == S_K2LD) || (state_q == S_K1LD);
  assign o_core_start    = (state_q == S_TWR)  || (state_q == S_BREQ);
  assign o_error         = error_q;
  assign o_core_key      = core_key_q;
  assign o_core_data     = core_data_q;
  assign o_data          = data_out_q;

endmodule

// File: tb/tb_serpent_xts_sector_ctrl.sv
// Self-checking bench for serpent_xts_sector_ctrl: mock core (2-cycle latency, data ^ key[127:0]),
// randomized host source/sink, and a sector-level XTS model that predicts every core and output transfer.
module tb_serpent_xts_sector_ctrl;
  localparam int CNT_W = 16;
  localparam int TMO_W = 10;

  logic             clk = 1'b0;
  logic             i_rst;
  logic             i_start;
  logic [255:0]     i_key1, i_key2;
  logic [127:0]     i_sector;
  logic [CNT_W-1:0] i_num_blocks;
  logic             o_busy;
  logic [127:0]     i_data;
  logic             i_data_valid, o_data_ready;
  logic [127:0]     o_data;
  logic             o_data_valid, i_data_ready;
  logic             o_done, o_error;
  logic [255:0]     o_core_key;
  logic             o_core_key_load, i_core_key_ready;
  logic [127:0]     o_core_data;
  logic             o_core_start;
  logic [127:0]     i_core_data;
  logic             i_core_valid;

  serpent_xts_sector_ctrl #(.CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_key1(i_key1), .i_key2(i_key2),
    .i_sector(i_sector), .i_num_blocks(i_num_blocks), .o_busy(o_busy),
    .i_data(i_data), .i_data_valid(i_data_valid), .o_data_ready(o_data_ready),
    .o_data(o_data), .o_data_valid(o_data_valid), .i_data_ready(i_data_ready),
    .o_done(o_done), .o_error(o_error), .o_core_key(o_core_key),
    .o_core_key_load(o_core_key_load), .i_core_key_ready(i_core_key_ready),
    .o_core_data(o_core_data), .o_core_start(o_core_start),
    .i_core_data(i_core_data), .i_core_valid(i_core_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model expectations and logs
  logic [255:0] exp_keys[$];
  logic [127:0] exp_core[$], exp_out[$], src_q[$], pt_q[$], core_log[$], out_log[$];
  int           kl_cyc[$], cs_cyc[$];
  int           cyc = 0, done_cyc = 0, last_acc_cyc = 0, err_cyc = 0;
  int           n_busy = 0, n_kl = 0, n_cs = 0, n_done = 0, n_err = 0, n_dv = 0, hold_cycles = 0;
  int           out_idx = 0, stall_at = -1, stall_left = 0;
  bit           saw_done = 0;

  // Mock core and host state
  logic [127:0] mock_key = '0, cd0 = '0, cd1 = '0;
  bit           kr_pend = 0, cv0 = 0, cv1 = 0, mute_core = 0;
  bit           src_pend = 0, rand_gaps = 0, rand_ready = 0, start_noise = 0;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand128(), rand128()};
  endfunction

  // Multiply by x modulo x^128 + x^7 + x^2 + x + 1.
  function automatic logic [127:0] mul_alpha(input logic [127:0] t);
    logic [128:0] w;
    w = {t, 1'b0};
    if (w[128]) w = w ^ {1'b1, 120'h0, 8'h87};
    return w[127:0];
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: DUT event with nothing expected (cycle %0d)", name, cyc);
  endtask

  // One clock: drive mock/host at the falling edge, then compare every visible output.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    i_core_key_ready = kr_pend;
    kr_pend = o_core_key_load;
    if (o_core_key_load) mock_key = o_core_key[127:0];
    i_core_valid = cv1;
    i_core_data  = cd1;
    cv1 = cv0;
    cd1 = cd0;
    cv0 = o_core_start && !mute_core;
    cd0 = o_core_data ^ mock_key;

    if (src_pend && src_q.size() > 0) src_q.delete(0);
    i_data_valid = (src_q.size() > 0) && (!rand_gaps || $urandom_range(3) != 0);
    i_data       = i_data_valid ? src_q[0] : rand128();
    src_pend     = o_data_ready && i_data_valid;

    if (o_data_valid && out_idx == stall_at && stall_left > 0) begin
      i_data_ready = 1'b0;
      stall_left--;
    end else begin
      i_data_ready = !rand_ready || ($urandom_range(3) != 0);
    end
    if (start_noise) i_start = o_busy && ($urandom_range(7) == 0);

    if (o_busy) n_busy++;
    if (!o_busy)
      check("idle_quiet", {o_data_ready, o_data_valid, o_core_start, o_core_key_load, o_done}, 5'b0);
    if (o_core_key_load) begin
      n_kl++;
      kl_cyc.push_back(cyc);
      if (exp_keys.size() == 0) fail_now("key_load_unexpected");
      else check("core_key", o_core_key, exp_keys.pop_front());
    end
    if (o_core_start) begin
      n_cs++;
      cs_cyc.push_back(cyc);
      core_log.push_back(o_core_data);
      if (exp_core.size() == 0) fail_now("core_start_unexpected");
      else check("core_data", o_core_data, exp_core.pop_front());
    end
    if (o_data_valid) begin
      n_dv++;
      check("out_exclusive", {o_data_ready, o_core_start, o_done}, 3'b0);
      if (exp_out.size() == 0) fail_now("data_valid_unexpected");
      else begin
        check("out_data", o_data, exp_out[0]);
        if (i_data_ready) begin
          out_log.push_back(o_data);
          exp_out.delete(0);
          out_idx++;
          last_acc_cyc = cyc;
        end else begin
          hold_cycles++;
        end
      end
    end
    if (o_done) begin
      n_done++;
      done_cyc = cyc;
      saw_done = 1;
      check("done_all_consumed", {32'(exp_out.size()), 32'(exp_core.size()), 32'(exp_keys.size())}, '0);
      check("done_busy", o_busy, 1'b1);
    end
    if (o_error) begin
      n_err++;
      err_cyc = cyc;
      check("error_not_busy", o_busy, 1'b0);
    end
  endtask

  task automatic clear_model();
    exp_keys.delete(); exp_core.delete(); exp_out.delete(); src_q.delete();
    core_log.delete(); out_log.delete(); kl_cyc.delete(); cs_cyc.delete();
    src_pend = 0; out_idx = 0; saw_done = 0; stall_at = -1; stall_left = 0;
  endtask

  // Predicts the whole sector from the XTS rules, then pulses i_start with the plaintexts in pt_q.
  task automatic start_sector(input logic [255:0] k1, input logic [255:0] k2,
                              input logic [127:0] sec, input int n);
    logic [127:0] t;
    logic [127:0] x;
    clear_model();
    if (n > 0) begin
      exp_keys.push_back(k2);
      exp_keys.push_back(k1);
      exp_core.push_back(sec);
      t = sec ^ k2[127:0];
      for (int i = 0; i < n; i++) begin
        x = pt_q[i] ^ t;
        exp_core.push_back(x);
        exp_out.push_back((x ^ k1[127:0]) ^ t);
        t = mul_alpha(t);
      end
      src_q = pt_q;
    end
    i_key1 = k1; i_key2 = k2; i_sector = sec; i_num_blocks = CNT_W'(n);
    i_start = 1'b1;
    cycle();
    i_start = 1'b0;
    i_key1 = rand256(); i_key2 = rand256(); i_sector = rand128(); i_num_blocks = CNT_W'($urandom);
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (!saw_done && k < budget) begin
      cycle();
      k++;
    end
    check(name, saw_done, 1'b1);
    repeat (2) cycle();
  endtask

  task automatic fill_pt(input int n, input bit zero);
    pt_q.delete();
    for (int i = 0; i < n; i++) pt_q.push_back(zero ? 128'h0 : rand128());
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int k, snap_busy, snap_kl, snap_cs, snap_done, snap_err, snap_dv, n;
    i_rst = 1'b1; i_start = 1'b0; i_key1 = '0; i_key2 = '0; i_sector = '0; i_num_blocks = '0;
    i_data = '0; i_data_valid = 1'b0; i_data_ready = 1'b0;
    i_core_key_ready = 1'b0; i_core_data = '0; i_core_valid = 1'b0;
    repeat (2) cycle();
    check("rst_flags", {o_busy, o_data_ready, o_data_valid, o_done, o_error, o_core_key_load, o_core_start}, '0);
    check("rst_core_key", o_core_key, '0);
    check("rst_buses", {o_core_data, o_data}, '0);
    i_rst = 1'b0;
    check("model_alpha_wrap", mul_alpha(128'h8000_0000_0000_0000_0000_0000_0000_0001), 128'h85);
    check("model_alpha_shift", mul_alpha(128'h4000_0000_0000_0000_0000_0000_0000_0003), 128'h8000_0000_0000_0000_0000_0000_0000_0006);
    cycle();

    // Single block: T = 1, C = 0, fixed load/start order.
    fill_pt(1, 1);
    start_sector({rand128(), 128'h0}, {rand128(), 128'h1}, 128'h0, 1);
    wait_done("t1_done", 200);
    check("t1_ncore", core_log.size(), 2);
    if (core_log.size() == 2) check("t1_block_in", core_log[1], 128'h1);
    check("t1_nout", out_log.size(), 1);
    if (out_log.size() == 1) check("t1_cipher", out_log[0], 128'h0);
    if (kl_cyc.size() == 2 && cs_cyc.size() == 2)
      check("t1_order", (kl_cyc[0] < cs_cyc[0]) && (cs_cyc[0] < kl_cyc[1]) && (kl_cyc[1] < cs_cyc[1]), 1'b1);
    else
      fail_now("t1_order_counts");
    check("t1_done_after_accept", done_cyc - last_acc_cyc, 1);

    // Tweak wrap: second block sees T*alpha = 0x85.
    fill_pt(2, 1);
    start_sector({rand128(), 128'h0}, {rand128(), 128'h8000_0000_0000_0000_0000_0000_0000_0001}, 128'h0, 2);
    wait_done("t2_done", 300);
    check("t2_ncore", core_log.size(), 3);
    if (core_log.size() == 3) begin
      check("t2_block0_in", core_log[1], 128'h8000_0000_0000_0000_0000_0000_0000_0001);
      check("t2_block1_in", core_log[2], 128'h85);
    end

    // Empty sector: straight to DONE, one busy cycle, no core traffic.
    snap_busy = n_busy; snap_kl = n_kl; snap_cs = n_cs; snap_done = n_done;
    fill_pt(0, 1);
    start_sector(rand256(), rand256(), rand128(), 0);
    wait_done("t3_done", 20);
    check("t3_busy_cycles", n_busy - snap_busy, 1);
    check("t3_no_core", {32'(n_kl - snap_kl), 32'(n_cs - snap_cs)}, '0);
    check("t3_one_done", n_done - snap_done, 1);

    // Backpressure: block 2 held for 5 cycles with stable data and no new core work.
    fill_pt(3, 0);
    start_sector(rand256(), rand256(), rand128(), 3);
    stall_at = 1; stall_left = 5; hold_cycles = 0;
    wait_done("t4_done", 300);
    check("t4_hold_cycles", hold_cycles, 5);
    check("t4_nout", out_log.size(), 3);

    // Randomized sectors with gaps, backpressure and stray i_start pulses.
    rand_gaps = 1; rand_ready = 1; start_noise = 1;
    for (int s = 0; s < 8; s++) begin
      n = (s == 7) ? 24 : $urandom_range(1, 6);
      fill_pt(n, 0);
      start_sector(rand256(), rand256(), rand128(), n);
      wait_done("rand_done", 60 * n + 100);
      check("rand_nout", out_log.size(), n);
    end
    rand_gaps = 0; rand_ready = 0; start_noise = 0; i_start = 1'b0;

    // Watchdog: the tweak encrypt never answers. 1023 cycles in TWW, error pulse in the next one.
    mute_core = 1;
    snap_err = n_err;
    fill_pt(1, 0);
    start_sector(rand256(), rand256(), rand128(), 1);
    k = 0;
    while (n_err == snap_err && k < 1200) begin
      cycle();
      k++;
    end
    check("t5_error_seen", n_err - snap_err, 1);
    if (cs_cyc.size() > 0) check("t5_latency", err_cyc - cs_cyc[0], 1024);
    else fail_now("t5_no_tweak_start");
    check("t5_key1_never_loaded", exp_keys.size(), 1);
    clear_model();
    mute_core = 0;
    repeat (5) cycle();
    check("t5_error_single", n_err - snap_err, 1);
    fill_pt(2, 0);
    start_sector(rand256(), rand256(), rand128(), 2);
    wait_done("t5_restart_done", 300);
    check("t5_restart_nout", out_log.size(), 2);

    // Async reset while BW waits; the late core answer must be ignored.
    fill_pt(2, 0);
    start_sector(rand256(), rand256(), rand128(), 2);
    k = 0;
    while (cs_cyc.size() < 2 && k < 100) begin
      cycle();
      k++;
    end
    check("t6_reach_breq", cs_cyc.size(), 2);
    cycle();
    check("t6_busy_pre", o_busy, 1'b1);
    i_rst = 1'b1;
    #1;
    check("t6_rst_flags", {o_busy, o_data_ready, o_data_valid, o_done, o_error, o_core_key_load, o_core_start}, '0);
    check("t6_rst_core_key", o_core_key, '0);
    check("t6_rst_buses", {o_core_data, o_data}, '0);
    clear_model();
    snap_dv = n_dv; snap_busy = n_busy;
    cycle();
    i_rst = 1'b0;
    repeat (20) cycle();
    check("t6_no_valid_after", n_dv - snap_dv, 0);
    check("t6_stays_idle", n_busy - snap_busy, 0);

    // Clean sector after the reset.
    fill_pt(3, 0);
    start_sector(rand256(), rand256(), rand128(), 3);
    wait_done("t6_after_done", 300);
    check("t6_after_nout", out_log.size(), 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
